// File: rtl/mem_port_arbiter4_pkg.sv
// Shared definitions for the 4-way memory port arbiter: state encoding,
// requester count and the counter-width helper.
package mem_port_arbiter4_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Counter width able to hold values up to n with one spare bit.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning
// ptr+1, ptr+2, ... modulo 4.
module rr_pick4
    import mem_port_arbiter4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            any,
    output logic [1:0]      idx
);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        logic [1:0] cand_s;
        any    = |req;
        idx    = ptr;
        cand_s = ptr;
        for (int i = NREQ; i >= 1; i--) begin
            cand_s = ptr + 2'(i);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter/sequencer sharing one memory port among 4 requesters,
// with bounded locked bursts and a response timeout.
module mem_port_arbiter4
    import mem_port_arbiter4_pkg::*;
#(
    parameter int MAXBURST = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  logic            mem_ready,
    output logic [1:0]      sel,
    output logic [NREQ-1:0] gnt,
    output logic            mem_valid,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            busy
);

    localparam int BW = cnt_width(MAXBURST);
    localparam int TW = cnt_width(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1'b1);
    localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1'b1);
    localparam logic          TMO_EN     = (TIMEOUT != 0);

    state_e            state_r, state_nxt_s;
    logic [1:0]        ptr_r, ptr_nxt_s;
    logic [1:0]        sel_r, sel_nxt_s;
    logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
    logic [BW-1:0]     burst_cnt_r, burst_nxt_s;
    logic [TW-1:0]     tmo_cnt_r, tmo_nxt_s;

    logic              pick_any_s;
    logic [1:0]        pick_idx_s;
    logic              xfer_s;
    logic              tmo_hit_s;
    logic              burst_more_s;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    assign xfer_s       = (state_r == ST_BUSY) & mem_ready;
    assign tmo_hit_s    = TMO_EN & (state_r == ST_BUSY) & ~mem_ready & (tmo_cnt_r == TMO_LAST);
    assign burst_more_s = lock[sel_r] & req[sel_r] & (burst_cnt_r < BURST_LAST);

    // State and grant registers; ptr resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 2'd3;
            sel_r       <= 2'd0;
            gnt_r       <= 4'b0000;
            burst_cnt_r <= '0;
            tmo_cnt_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            sel_r       <= sel_nxt_s;
            gnt_r       <= gnt_nxt_s;
            burst_cnt_r <= burst_nxt_s;
            tmo_cnt_r   <= tmo_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/burst/timeout in BUSY.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        sel_nxt_s   = sel_r;
        gnt_nxt_s   = gnt_r;
        burst_nxt_s = burst_cnt_r;
        tmo_nxt_s   = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = ST_BUSY;
                    ptr_nxt_s   = pick_idx_s;
                    sel_nxt_s   = pick_idx_s;
                    gnt_nxt_s   = 4'b0001 << pick_idx_s;
                    burst_nxt_s = '0;
                    tmo_nxt_s   = '0;
                end else begin
                    gnt_nxt_s   = 4'b0000;
                end
            end
            ST_BUSY: begin
                if (xfer_s) begin
                    tmo_nxt_s = '0;
                    if (burst_more_s) begin
                        burst_nxt_s = burst_cnt_r + BURST_ONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        gnt_nxt_s   = 4'b0000;
                        burst_nxt_s = '0;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = 4'b0000;
                    burst_nxt_s = '0;
                    tmo_nxt_s   = '0;
                end else begin
                    tmo_nxt_s = tmo_cnt_r + TMO_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 4'b0000;
            end
        endcase
    end

    // Outputs: done/err are combinational so the requester sees completion in the ready cycle.
    always_comb begin
        sel       = sel_r;
        gnt       = gnt_r;
        mem_valid = (state_r == ST_BUSY);
        busy      = (state_r == ST_BUSY);
        err       = tmo_hit_s;
        if (xfer_s || tmo_hit_s) begin
            done = gnt_r;
        end else begin
            done = 4'b0000;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed self-checking bench for mem_port_arbiter4 (MAXBURST=4, TIMEOUT=8).
module tb_mem_port_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       mem_ready;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       mem_valid;
    logic [3:0] done;
    logic       err;
    logic       busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    mem_port_arbiter4 #(.MAXBURST(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .mem_ready (mem_ready),
        .sel       (sel),
        .gnt       (gnt),
        .mem_valid (mem_valid),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The granted requester must hold req until its completion cycle.
    always @(negedge clk) begin
        if (rst_n && mem_valid && (done == 4'b0000)) begin
            assert (req[sel]) else $error("granted req dropped before done, sel=%0d", sel);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        lock = 4'b0000;
        mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        lock = 4'b0000;
        mem_ready = 1'b0;
        apply_reset();

        // reset state
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        #1;
        chk("idle_rdy_done", 32'(done), 32'h0);
        tick();
        chk("idle_rdy_busy", 32'(busy), 32'd0);
        chk("idle_rdy_gnt", 32'(gnt), 32'h0);
        chk("idle_rdy_done2", 32'(done), 32'h0);
        mem_ready = 1'b0;

        // single transaction, ready 2 cycles after grant
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'(sel), 32'd0);
        chk("t1_valid1", 32'(mem_valid), 32'd1);
        chk("t1_done1", 32'(done), 32'h0);
        tick();
        chk("t1_valid2", 32'(mem_valid), 32'd1);
        chk("t1_done2", 32'(done), 32'h0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("t1_valid3", 32'(mem_valid), 32'd1);
        chk("t1_done3", 32'(done), 32'h1);
        chk("t1_err3", 32'(err), 32'd0);
        tick();
        req = 4'b0000;
        mem_ready = 1'b0;
        chk("t1_idle_gnt", 32'(gnt), 32'h0);
        chk("t1_idle_valid", 32'(mem_valid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("t1_no_regrant", 32'(gnt), 32'h0);

        // four continuous requesters, no lock: 0,1,2,3,0 with a bubble each
        apply_reset();
        req = 4'b1111;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr_sel%0d", k), 32'(sel), 32'(k % 4));
            chk($sformatf("rr_done%0d", k), 32'(done), 32'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_bubble%0d", k), 32'(busy), 32'd0);
            chk($sformatf("rr_bubble_gnt%0d", k), 32'(gnt), 32'h0);
        end
        req = 4'b0000;
        mem_ready = 1'b0;

        // locked burst of MAXBURST=4 by requester 0, then requester 1
        apply_reset();
        req = 4'b0011;
        lock = 4'b0001;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("bu_gnt%0d", k), 32'(gnt), 32'h1);
            chk($sformatf("bu_done%0d", k), 32'(done), 32'h1);
            chk($sformatf("bu_busy%0d", k), 32'(busy), 32'd1);
        end
        tick();
        chk("bu_idle_busy", 32'(busy), 32'd0);
        chk("bu_idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("bu_next_gnt", 32'(gnt), 32'h2);
        chk("bu_next_done", 32'(done), 32'h2);
        tick();
        req = 4'b0000;
        lock = 4'b0000;
        mem_ready = 1'b0;
        chk("bu_end_busy", 32'(busy), 32'd0);

        // timeout abort on the 8th BUSY cycle
        apply_reset();
        req = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("to_gnt%0d", k), 32'(gnt), 32'h4);
            chk($sformatf("to_err%0d", k), 32'(err), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("to_done%0d", k), 32'(done), (k == 8) ? 32'h4 : 32'h0);
        end
        tick();
        req = 4'b0101;
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_idle_err", 32'(err), 32'd0);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'h1);
        chk("to_next_sel", 32'(sel), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("to_next_done", 32'(done), 32'h1);
        tick();
        req = 4'b0000;
        mem_ready = 1'b0;

        // asynchronous reset mid-BUSY, then ptr=3 priority
        apply_reset();
        req = 4'b0010;
        tick();
        chk("ar_pre_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        req = 4'b0000;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_valid", 32'(mem_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'h0);
        #2;
        rst_n = 1'b1;
        req = 4'b1000;
        tick();
        chk("ar_post_gnt", 32'(gnt), 32'h8);
        chk("ar_post_sel", 32'(sel), 32'd3);
        mem_ready = 1'b1;
        #1;
        chk("ar_post_done", 32'(done), 32'h8);
        tick();
        req = 4'b0000;
        mem_ready = 1'b0;
        tick();
        chk("ar_final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
